mem_stage_lsu: RTL

- RV32I memory stage: consumer end of the execute-stage valid/ready interface.
- Takes the EX result (effective address or ALU value), store data, funct3 and write-back controls.
- Performs word-aligned load/store transactions on a req/ack data-memory port, with byte-lane steering, sign/zero extension and misalignment/timeout detection.
- Presents one write-back record per instruction to the WB stage over valid/ready.

---
 rtl/mem_stage_lsu_pkg.sv | 27 ++
 rtl/mem_stage_lsu_align.sv | 92 +++++++++
 rtl/mem_stage_lsu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_pkg
// Shared definitions for the RV32I memory stage:
//   - state_e : memory-stage controller states (IDLE / BUSY / HOLD)
//   - funct3 encodings for the supported loads and stores
// ---------------------------------------------------------------------------
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no record held
        BUSY = 2'd1,   // data-memory transaction outstanding (dmem_req=1)
        HOLD = 2'd2    // write-back record presented (valid_next=1)
    } state_e;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_align
// Combinational byte-lane logic for the memory stage.
//   Store/legality side (driven from the incoming EX record):
//     mem_ren_i, mem_wen_i : access kind
//     funct3_i             : access size/sign
//     addr_lo_i            : effective address bits [1:0]
//     st_data_i            : rs2 store data
//     legal_o              : access is a legal, naturally aligned load/store
//                            (1 when the record is not a memory access)
//     wstrb_o, wdata_o     : byte enables and lane-replicated store data
//   Load side (driven from the registered transaction):
//     ld_funct3_i, ld_lane_i : funct3 and address bits [1:0] of the load
//     rdata_i                : word returned by data memory
//     ld_value_o             : selected byte/half, sign- or zero-extended
// ---------------------------------------------------------------------------
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic        mem_ren_i,
    input  logic        mem_wen_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic        legal_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_value_o
);

    logic        half_ok;
    logic        word_ok;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign half_ok = ~addr_lo_i[0];
    assign word_ok = (addr_lo_i == 2'b00);

    always_comb begin
        legal_o = 1'b0;
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        if (mem_ren_i && !mem_wen_i) begin
            case (funct3_i)
                F3_LB, F3_LBU: legal_o = 1'b1;
                F3_LH, F3_LHU: legal_o = half_ok;
                F3_LW:         legal_o = word_ok;
                default:       legal_o = 1'b0;
            endcase
        end else if (mem_wen_i && !mem_ren_i) begin
            case (funct3_i)
                F3_SB: begin
                    legal_o = 1'b1;
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{st_data_i[7:0]}};
                end
                F3_SH: begin
                    legal_o = half_ok;
                    wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o = {2{st_data_i[15:0]}};
                end
                F3_SW: begin
                    legal_o = word_ok;
                    wstrb_o = 4'b1111;
                    wdata_o = st_data_i;
                end
                default: legal_o = 1'b0;
            endcase
        end else if (!mem_ren_i && !mem_wen_i) begin
            // Plain ALU record: nothing to misalign.
            legal_o = 1'b1;
        end
    end

    assign ld_byte = rdata_i[{ld_lane_i, 3'b000} +: 8];
    assign ld_half = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        ld_value_o = rdata_i;
        case (ld_funct3_i)
            F3_LB:   ld_value_o = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_value_o = {24'h0, ld_byte};
            F3_LH:   ld_value_o = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_value_o = {16'h0, ld_half};
            default: ld_value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// RV32I memory stage. Accepts one EX record at a time, performs at most one
// word-aligned data-memory transaction for it, and presents one write-back
// record to WB.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. valid_last/valid_next never wait on their ready, and a
// producer holds its payload stable while valid is high and ready is low.
// dmem_req is held, with address/data stable, until the cycle dmem_ack=1.
//
// Ports:
//   clock, reset               : clock, synchronous active-high reset
//   valid_last / ready_last    : EX -> MEM record handshake
//   R_wen, mem_wen, mem_ren,
//   rd, funct3, EX_result,
//   rs2_value, pc              : EX record payload
//   dmem_req/we/addr/wstrb/
//   wdata, dmem_rdata, dmem_ack: data-memory req/ack port
//   valid_next / ready_next    : MEM -> WB record handshake
//   R_wen_next, rd_next,
//   wb_value, pc_out           : WB record payload
//   err_misalign               : pulse after accepting a misaligned/illegal access
//   err_timeout                : pulse when dmem_ack never arrived
// ---------------------------------------------------------------------------
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_last,
    output logic        ready_last,
    input  logic        R_wen,
    input  logic        mem_wen,
    input  logic        mem_ren,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [31:0] EX_result,
    input  logic [31:0] rs2_value,
    input  logic [31:0] pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        valid_next,
    input  logic        ready_next,
    output logic        R_wen_next,
    output logic [4:0]  rd_next,
    output logic [31:0] wb_value,
    output logic [31:0] pc_out,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Last count value before the limit: the BUSY cycle that sees this value
    // without an ack is the TIMEOUT_CYCLES-th one.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d, start_state;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept, start_mem, bad_mem, timeout_hit;

    logic               dmem_we_q;
    logic [31:0]        dmem_addr_q, dmem_wdata_q;
    logic [3:0]         dmem_wstrb_q;
    logic               is_load_q, r_wen_saved_q;
    logic [2:0]         ld_funct3_q;
    logic [1:0]         ld_lane_q;
    logic               r_wen_next_q, err_mis_q, err_to_q;
    logic [4:0]         rd_q;
    logic [31:0]        pc_q, wb_value_q;

    logic               legal;
    logic [3:0]         st_wstrb;
    logic [31:0]        st_wdata, ld_value;

    mem_stage_lsu_align u_align (
        .mem_ren_i   (mem_ren),
        .mem_wen_i   (mem_wen),
        .funct3_i    (funct3),
        .addr_lo_i   (EX_result[1:0]),
        .st_data_i   (rs2_value),
        .legal_o     (legal),
        .wstrb_o     (st_wstrb),
        .wdata_o     (st_wdata),
        .ld_funct3_i (ld_funct3_q),
        .ld_lane_i   (ld_lane_q),
        .rdata_i     (dmem_rdata),
        .ld_value_o  (ld_value)
    );

    // ---------------- FSM: next state and handshake ----------------
    always_comb begin
        state_d     = state_q;
        ready_last  = 1'b0;
        timeout_hit = 1'b0;
        start_mem   = (mem_ren | mem_wen) & legal;
        bad_mem     = (mem_ren | mem_wen) & ~legal;
        start_state = start_mem ? BUSY : HOLD;
        case (state_q)
            IDLE: begin
                ready_last = 1'b1;
                if (valid_last) state_d = start_state;
            end
            BUSY: begin
                // An ack arriving on the limit cycle completes normally.
                timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST) && !dmem_ack;
                if (dmem_ack || timeout_hit) state_d = HOLD;
            end
            HOLD: begin
                ready_last = ready_next;
                if (ready_next) state_d = valid_last ? start_state : IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = valid_last & ready_last;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 32'h0;
            dmem_wstrb_q  <= 4'h0;
            dmem_wdata_q  <= 32'h0;
            is_load_q     <= 1'b0;
            r_wen_saved_q <= 1'b0;
            ld_funct3_q   <= 3'b000;
            ld_lane_q     <= 2'b00;
            r_wen_next_q  <= 1'b0;
            err_mis_q     <= 1'b0;
            err_to_q      <= 1'b0;
            rd_q          <= 5'd0;
            pc_q          <= 32'h0;
            wb_value_q    <= 32'h0;
        end else begin
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
            if (accept) begin
                rd_q          <= rd;
                pc_q          <= pc;
                is_load_q     <= mem_ren;
                r_wen_saved_q <= R_wen;
                ld_funct3_q   <= funct3;
                ld_lane_q     <= EX_result[1:0];
                if (start_mem) begin
                    cnt_q        <= '0;
                    dmem_we_q    <= mem_wen;
                    dmem_addr_q  <= {EX_result[31:2], 2'b00};
                    dmem_wstrb_q <= mem_wen ? st_wstrb : 4'h0;
                    dmem_wdata_q <= mem_wen ? st_wdata : 32'h0;
                end else if (bad_mem) begin
                    r_wen_next_q <= 1'b0;
                    wb_value_q   <= 32'h0;
                    err_mis_q    <= 1'b1;
                end else begin
                    r_wen_next_q <= R_wen;
                    wb_value_q   <= EX_result;
                end
            end
            // accept and BUSY are exclusive: ready_last is low in BUSY.
            if (state_q == BUSY) begin
                if (dmem_ack) begin
                    wb_value_q   <= is_load_q ? ld_value : 32'h0;
                    r_wen_next_q <= is_load_q & r_wen_saved_q;
                end else if (timeout_hit) begin
                    wb_value_q   <= 32'h0;
                    r_wen_next_q <= 1'b0;
                    err_to_q     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign dmem_req     = (state_q == BUSY);
    assign valid_next   = (state_q == HOLD);
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wstrb   = dmem_wstrb_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign R_wen_next   = r_wen_next_q;
    assign rd_next      = rd_q;
    assign wb_value     = wb_value_q;
    assign pc_out       = pc_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;

endmodule
